// File: rtl/tdd_sched_pkg.sv
// rtl/tdd_sched_pkg.sv - shared types, defaults and window decode for the TDD scheduler
package tdd_sched_pkg;

    localparam int CW_DEF = 24;
    localparam int AW_DEF = 16;
    localparam int WIN_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADJ  = 2'd2
    } state_t;

    // Half-open [start, stop) window; start > stop wraps through zero, start == stop is empty.
    function automatic logic win_hit(
        input logic [WIN_W-1:0] cnt,
        input logic [WIN_W-1:0] start,
        input logic [WIN_W-1:0] stop
    );
        if (start <= stop) begin
            return (cnt >= start) && (cnt < stop);
        end
        return (cnt >= start) || (cnt < stop);
    endfunction

endpackage

// File: rtl/tdd_sched_if.sv
// rtl/tdd_sched_if.sv - control and status bundle between register space/DMA and the scheduler
interface tdd_sched_if #(
    parameter int CW = tdd_sched_pkg::CW_DEF,
    parameter int AW = tdd_sched_pkg::AW_DEF
);
    logic          en;
    logic          tdd_mode;
    logic          sample_ce;
    logic [CW-1:0] frame_len;
    logic [CW-1:0] rstart;
    logic [CW-1:0] rend;
    logic [CW-1:0] tstart;
    logic [CW-1:0] tend;
    logic [AW-1:0] frame_adj;
    logic          adj_req;
    logic          ien;
    logic          oen;
    logic          sync;
    logic [CW-1:0] sample_cnt;
    logic [31:0]   frame_cnt;
    logic          adj_pending;

    modport master (
        output en, tdd_mode, sample_ce, frame_len, rstart, rend, tstart, tend,
               frame_adj, adj_req,
        input  ien, oen, sync, sample_cnt, frame_cnt, adj_pending
    );

    modport slave (
        input  en, tdd_mode, sample_ce, frame_len, rstart, rend, tstart, tend,
               frame_adj, adj_req,
        output ien, oen, sync, sample_cnt, frame_cnt, adj_pending
    );
endinterface

// File: rtl/tdd_sched_window.sv
// rtl/tdd_sched_window.sv - combinational [start, stop) window decode with wrap
module tdd_window
    import tdd_sched_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] win_start,
    input  logic [CW-1:0] win_stop,
    output logic          hit
);
    assign hit = win_hit(WIN_W'(cnt), WIN_W'(win_start), WIN_W'(win_stop));
endmodule

// File: rtl/tdd_sched.sv
// rtl/tdd_sched.sv - TDD frame scheduler: sample counter, one-shot frame adjust, rx/tx windows
module tdd_sched
    import tdd_sched_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    tdd_sched_if.slave bus
);
    state_t              state;
    state_t              state_nx;
    logic [CW-1:0]       sample_cnt_q;
    logic [CW-1:0]       limit;
    logic [31:0]         frame_cnt_q;
    logic [AW-1:0]       adj_val;
    logic [AW-1:0]       adj_act;
    logic                adj_pending_q;
    logic                wrapped;
    logic                ien_q;
    logic                oen_q;
    logic                sync_q;
    logic signed [CW:0]  adj_ext;
    logic signed [CW:0]  adj_sum;
    logic                frame_end;
    logic                keep_running;
    logic                rx_hit;
    logic                tx_hit;

    // adj_val collects requests; adj_act is frozen for the duration of an ADJ frame.
    assign adj_ext = {{(CW + 1 - AW){adj_act[AW-1]}}, adj_act};
    assign adj_sum = $signed({1'b0, bus.frame_len}) + adj_ext;

    always_comb begin
        limit = bus.frame_len;
        if (state == ST_ADJ) begin
            if (adj_sum[CW] || (adj_sum == '0)) begin
                limit = '0;
            end else begin
                limit = adj_sum[CW-1:0];
            end
        end
    end

    assign frame_end    = bus.sample_ce && (sample_cnt_q == limit);
    assign keep_running = (state != ST_IDLE) && (state_nx != ST_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.en) state_nx = adj_pending_q ? ST_ADJ : ST_RUN;
            ST_RUN: begin
                if (!bus.en) begin
                    state_nx = ST_IDLE;
                end else if (frame_end && adj_pending_q) begin
                    state_nx = ST_ADJ;
                end
            end
            ST_ADJ: begin
                if (!bus.en) begin
                    state_nx = ST_IDLE;
                end else if (frame_end) begin
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    tdd_window #(.CW(CW)) u_rx_win (
        .cnt       (sample_cnt_q),
        .win_start (bus.rstart),
        .win_stop  (bus.rend),
        .hit       (rx_hit)
    );

    tdd_window #(.CW(CW)) u_tx_win (
        .cnt       (sample_cnt_q),
        .win_start (bus.tstart),
        .win_stop  (bus.tend),
        .hit       (tx_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            sample_cnt_q  <= '0;
            frame_cnt_q   <= '0;
            adj_val       <= '0;
            adj_act       <= '0;
            adj_pending_q <= 1'b0;
            wrapped       <= 1'b0;
            ien_q         <= 1'b0;
            oen_q         <= 1'b0;
            sync_q        <= 1'b0;
        end else begin
            state <= state_nx;

            if ((state == ST_IDLE) || (state_nx == ST_IDLE)) begin
                sample_cnt_q <= '0;
                frame_cnt_q  <= '0;
            end else if (frame_end) begin
                sample_cnt_q <= '0;
                frame_cnt_q  <= frame_cnt_q + 32'd1;
            end else if (bus.sample_ce) begin
                sample_cnt_q <= sample_cnt_q + CW'(1);
            end

            // Marks the first sample of a frame, including the one entered from IDLE.
            wrapped <= ((state == ST_IDLE) && (state_nx != ST_IDLE)) || (keep_running && frame_end);

            if ((state_nx == ST_ADJ) && (state != ST_ADJ)) begin
                adj_act       <= adj_val;
                adj_pending_q <= 1'b0;
            end
            // A request on the entry cycle stays pending for the next RUN->ADJ entry.
            if (bus.adj_req) begin
                adj_val       <= bus.frame_adj;
                adj_pending_q <= 1'b1;
            end

            ien_q  <= keep_running && (!bus.tdd_mode || rx_hit);
            oen_q  <= keep_running && (!bus.tdd_mode || tx_hit);
            sync_q <= keep_running && wrapped;
        end
    end

    assign bus.ien         = ien_q;
    assign bus.oen         = oen_q;
    assign bus.sync        = sync_q;
    assign bus.sample_cnt  = sample_cnt_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.adj_pending = adj_pending_q;

endmodule

// File: tb/tb_tdd_sched.sv
// tb/tb_tdd_sched.sv - self-checking bench for tdd_sched against a frame-level model
module tb_tdd_sched;
    import tdd_sched_pkg::*;

    localparam int CW = CW_DEF;
    localparam int AW = AW_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdd_sched_if #(.CW(CW), .AW(AW)) bus ();

    tdd_sched #(.CW(CW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model: position in frame, frames done, one pending and one active adjustment.
    bit        m_run;
    int        m_pos;
    bit [31:0] m_frames;
    bit        m_in_adj;
    int        m_adj_cur;
    bit        m_pend;
    int        m_pend_val;
    bit        m_first;
    bit        e_ien;
    bit        e_oen;
    bit        e_sync;
    bit        t_run;
    bit        t_first;
    int        t_pos;
    int        t_len;

    int        sync_q[$];
    int        last_sync = -1;
    int        col_cyc   = 0;
    bit        cap_on    = 1'b0;
    logic [9:0] ien_mask;
    logic [9:0] oen_mask;
    int        prev_cnt  = -1;

    function automatic bit in_window(input int pos, input int s, input int e);
        if (s == e) return 1'b0;
        if (s < e) return (pos >= s) && (pos < e);
        return !((pos >= e) && (pos < s));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_frames = 0; m_in_adj = 0; m_adj_cur = 0;
        m_pend = 0; m_pend_val = 0; m_first = 0;
        e_ien = 0; e_oen = 0; e_sync = 0;
    endtask

    task automatic model_step();
        t_run   = m_run;
        t_pos   = m_pos;
        t_first = m_first;
        t_len   = int'(bus.frame_len);
        if (m_in_adj) begin
            t_len = t_len + m_adj_cur;
            if (t_len < 0) t_len = 0;
        end
        if (!m_run) begin
            m_first = 0;
            if (bus.en) begin
                m_run = 1; m_pos = 0; m_first = 1;
                m_in_adj = m_pend; m_adj_cur = m_pend_val; m_pend = 0;
            end
        end else if (!bus.en) begin
            m_run = 0; m_pos = 0; m_frames = 0; m_first = 0; m_in_adj = 0;
        end else if (bus.sample_ce && (m_pos == t_len)) begin
            m_pos = 0; m_frames = m_frames + 1; m_first = 1;
            if (m_in_adj) begin
                m_in_adj = 0;
            end else if (m_pend) begin
                m_in_adj = 1; m_adj_cur = m_pend_val; m_pend = 0;
            end
        end else if (bus.sample_ce) begin
            m_pos = m_pos + 1; m_first = 0;
        end else begin
            m_first = 0;
        end
        if (bus.adj_req) begin
            m_pend = 1;
            m_pend_val = int'($signed(bus.frame_adj));
        end
        e_ien  = t_run && m_run && (!bus.tdd_mode ||
                 in_window(t_pos, int'(bus.rstart), int'(bus.rend)));
        e_oen  = t_run && m_run && (!bus.tdd_mode ||
                 in_window(t_pos, int'(bus.tstart), int'(bus.tend)));
        e_sync = t_run && m_run && t_first;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("ien",         bus.ien,         e_ien);
            check("oen",         bus.oen,         e_oen);
            check("sync",        bus.sync,        e_sync);
            check("sample_cnt",  bus.sample_cnt,  m_pos);
            check("frame_cnt",   bus.frame_cnt,   m_frames);
            check("adj_pending", bus.adj_pending, m_pend);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            col_cyc++;
            if (bus.sync) begin
                if (last_sync >= 0) sync_q.push_back(col_cyc - last_sync);
                last_sync = col_cyc;
            end
            if (cap_on && (prev_cnt >= 0) && (prev_cnt < 10)) begin
                ien_mask[prev_cnt] = ien_mask[prev_cnt] | bus.ien;
                oen_mask[prev_cnt] = oen_mask[prev_cnt] | bus.oen;
            end
            prev_cnt = int'(bus.sample_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_syncs();
        sync_q.delete();
        last_sync = -1;
    endtask

    task automatic pulse_adj(input int v);
        bus.frame_adj = AW'(v);
        bus.adj_req   = 1'b1;
        tick(1);
        bus.adj_req   = 1'b0;
    endtask

    task automatic wait_adj_taken(input string name);
        int k;
        k = 0;
        while (bus.adj_pending && (k < 200)) begin
            tick(1);
            k++;
        end
        check(name, bus.adj_pending, 0);
    endtask

    initial begin
        int n13;
        int n8;
        int idx;
        bus.en = 0; bus.tdd_mode = 1; bus.sample_ce = 1; bus.frame_len = CW'(9);
        bus.rstart = CW'(2); bus.rend = CW'(5); bus.tstart = CW'(7); bus.tend = CW'(1);
        bus.frame_adj = '0; bus.adj_req = 0;
        ien_mask = '0; oen_mask = '0;
        tick(3);
        rst = 0;
        tick(2);
        check("rst_sample_cnt", bus.sample_cnt, 0);
        check("rst_frame_cnt",  bus.frame_cnt, 0);
        check("rst_ien",        bus.ien, 0);
        check("rst_oen",        bus.oen, 0);
        check("rst_adj_pending", bus.adj_pending, 0);

        // nominal 10-sample frames and window shapes
        clear_syncs();
        bus.en = 1;
        tick(3);
        cap_on = 1;
        tick(25);
        cap_on = 0;
        tick(8);
        check("run36_sample_cnt", bus.sample_cnt, 5);
        check("run36_frame_cnt",  bus.frame_cnt, 3);
        check("ien_mask", ien_mask, 10'b0000011100);
        check("oen_mask", oen_mask, 10'b1110000001);
        check("nom_sync_count", sync_q.size() >= 3, 1);
        foreach (sync_q[i]) check("nom_sync_interval", sync_q[i], 10);

        // +3 then -2 in separate frames
        clear_syncs();
        pulse_adj(3);
        check("adj_pending_set", bus.adj_pending, 1);
        wait_adj_taken("adj_p3_timeout");
        tick(30);
        pulse_adj(-2);
        wait_adj_taken("adj_m2_timeout");
        tick(30);
        n13 = 0; n8 = 0;
        foreach (sync_q[i]) begin
            if (sync_q[i] == 13) n13++;
            if (sync_q[i] == 8)  n8++;
        end
        check("adj_13_frames", n13, 1);
        check("adj_8_frames",  n8, 1);
        check("adj_other_frames", sync_q.size() - n13 - n8 - sync_q.find(x) with (x == 10).size(), 0);

        // second request during ADJ: ADJ(13), nominal(10), then second value (8)
        clear_syncs();
        pulse_adj(3);
        wait_adj_taken("adj2_first_timeout");
        tick(3);
        pulse_adj(-2);
        check("adj2_pending_in_adj", bus.adj_pending, 1);
        wait_adj_taken("adj2_second_timeout");
        tick(30);
        idx = -1;
        foreach (sync_q[i]) if ((idx < 0) && (sync_q[i] == 13)) idx = i;
        check("adj2_seq_found", idx >= 0, 1);
        check("adj2_seq_len", (idx >= 0) && (sync_q.size() > idx + 2), 1);
        if ((idx >= 0) && (sync_q.size() > idx + 2)) begin
            check("adj2_nominal_between", sync_q[idx+1], 10);
            check("adj2_second_value",    sync_q[idx+2], 8);
        end

        // FDD mode, sparse strobes, frozen counter, empty window
        bus.tdd_mode = 0;
        tick(20);
        check("fdd_ien", bus.ien, 1);
        check("fdd_oen", bus.oen, 1);
        bus.tdd_mode = 1;
        for (int i = 0; i < 24; i++) begin
            bus.sample_ce = i[0];
            tick(1);
        end
        bus.sample_ce = 0;
        tick(10);
        bus.sample_ce = 1;
        bus.rstart = CW'(4); bus.rend = CW'(4);
        tick(15);
        check("empty_win_ien", bus.ien, 0);
        bus.rstart = CW'(2); bus.rend = CW'(5);

        // en dropped mid-frame, even in FDD mode outputs go low
        bus.tdd_mode = 0;
        tick(4);
        bus.en = 0;
        tick(2);
        check("idle_sample_cnt", bus.sample_cnt, 0);
        check("idle_frame_cnt",  bus.frame_cnt, 0);
        check("idle_ien",  bus.ien, 0);
        check("idle_oen",  bus.oen, 0);
        check("idle_sync", bus.sync, 0);
        bus.tdd_mode = 1;

        // request latched in IDLE shapes the first frame
        pulse_adj(1);
        check("idle_adj_pending", bus.adj_pending, 1);
        clear_syncs();
        bus.en = 1;
        tick(30);
        check("idle_adj_count", sync_q.size() >= 1, 1);
        if (sync_q.size() >= 1) check("idle_adj_first_frame", sync_q[0], 11);

        // reset mid-frame discards a pending adjust
        pulse_adj(5);
        tick(4);
        #2 rst = 1;
        tick(1);
        check("rst_mid_adj_pending", bus.adj_pending, 0);
        check("rst_mid_sample_cnt",  bus.sample_cnt, 0);
        check("rst_mid_frame_cnt",   bus.frame_cnt, 0);
        check("rst_mid_ien",         bus.ien, 0);
        rst = 0;
        tick(4);
        check("restart_sample_cnt", bus.sample_cnt, 3);
        check("restart_frame_cnt",  bus.frame_cnt, 0);
        tick(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
